alu_ctrl_decode: RTL

- Registered decode stage that turns a 32-bit RV32I instruction into the 4-bit ALU select code, operand-mux selects, the sign-extended immediate and register indices for the execute stage.
- It is the producer side of the alusel/operand interface that the execute-stage ALU consumes.
- Sits between instruction fetch and execute, behind a one-entry valid/ready pipeline register with flush.

---
 rtl/alu_pkg.sv | 74 +++++++
 rtl/alu_ctrl_comb.sv | 128 ++++++++++++
 rtl/alu_ctrl_decode.sv | 77 +++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU select codes, RV32I opcodes and the decoded-instruction bundle
// passed from the decode stage to execute.
package alu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ALUSEL_W = 4;

  typedef enum logic [ALUSEL_W-1:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_SRA   = 4'b0110,
    ALU_SLL   = 4'b0111,
    ALU_SLT   = 4'b1000,
    ALU_SLTU  = 4'b1001,
    ALU_PASSB = 4'b1110,
    ALU_PASSA = 4'b1111
  } alusel_e;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IMM    = 7'b0010011,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111
  } opcode_e;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alusel_e         alusel;
    logic            asel;
    logic            bsel;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic            rd_we;
    logic            illegal;
  } decode_t;

  // Register-register / register-immediate funct3 map with the base funct7.
  function automatic alusel_e base_alu(input logic [2:0] f3);
    base_alu = ALU_ADD;
    case (f3)
      3'b000: base_alu = ALU_ADD;
      3'b001: base_alu = ALU_SLL;
      3'b010: base_alu = ALU_SLT;
      3'b011: base_alu = ALU_SLTU;
      3'b100: base_alu = ALU_XOR;
      3'b101: base_alu = ALU_SRL;
      3'b110: base_alu = ALU_OR;
      3'b111: base_alu = ALU_AND;
      default: base_alu = ALU_ADD;
    endcase
  endfunction

  function automatic decode_t reset_decode();
    decode_t d;
    d        = '0;
    d.alusel = ALU_PASSA;
    return d;
  endfunction

endpackage

// File: rtl/alu_ctrl_comb.sv
// Combinational RV32I decoder: raw instruction word to ALU/operand controls,
// immediate and register indices.
module alu_ctrl_comb
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output decode_t         dec
);

  logic [6:0]      funct7;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic            ill;

  assign funct7 = instr[31:25];
  assign f3     = instr[14:12];

  // Format immediates; instr[31] is always the sign bit.
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    dec        = '0;
    ill        = 1'b0;
    dec.alusel = ALU_ADD;
    dec.rd     = instr[11:7];
    dec.rs1    = instr[19:15];
    dec.rs2    = instr[24:20];
    dec.funct3 = f3;

    case (instr[6:0])
      OP_R: begin
        dec.rd_we = 1'b1;
        if (funct7 == F7_BASE) begin
          dec.alusel = base_alu(f3);
        end else if (funct7 == F7_ALT && f3 == 3'b000) begin
          dec.alusel = ALU_SUB;
        end else if (funct7 == F7_ALT && f3 == 3'b101) begin
          dec.alusel = ALU_SRA;
        end else begin
          ill = 1'b1;
        end
      end
      OP_IMM: begin
        dec.bsel  = 1'b1;
        dec.imm   = imm_i;
        dec.rd_we = 1'b1;
        // Shift-immediates reuse imm[11:5] as a funct7 qualifier.
        case (f3)
          3'b001: begin
            dec.alusel = ALU_SLL;
            ill        = (funct7 != F7_BASE);
          end
          3'b101: begin
            if (funct7 == F7_BASE) begin
              dec.alusel = ALU_SRL;
            end else if (funct7 == F7_ALT) begin
              dec.alusel = ALU_SRA;
            end else begin
              ill = 1'b1;
            end
          end
          default: dec.alusel = base_alu(f3);
        endcase
      end
      OP_LUI: begin
        dec.alusel = ALU_PASSB;
        dec.bsel   = 1'b1;
        dec.imm    = imm_u;
        dec.rd_we  = 1'b1;
      end
      OP_AUIPC: begin
        dec.asel  = 1'b1;
        dec.bsel  = 1'b1;
        dec.imm   = imm_u;
        dec.rd_we = 1'b1;
      end
      OP_LOAD: begin
        dec.bsel  = 1'b1;
        dec.imm   = imm_i;
        dec.rd_we = 1'b1;
        ill       = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end
      OP_STORE: begin
        dec.bsel = 1'b1;
        dec.imm  = imm_s;
        ill      = !(f3 inside {3'b000, 3'b001, 3'b010});
      end
      OP_BRANCH: begin
        dec.asel = 1'b1;
        dec.bsel = 1'b1;
        dec.imm  = imm_b;
        ill      = (f3 inside {3'b010, 3'b011});
      end
      OP_JAL: begin
        dec.asel  = 1'b1;
        dec.bsel  = 1'b1;
        dec.imm   = imm_j;
        dec.rd_we = 1'b1;
      end
      OP_JALR: begin
        dec.bsel  = 1'b1;
        dec.imm   = imm_i;
        dec.rd_we = 1'b1;
        ill       = (f3 != 3'b000);
      end
      default: ill = 1'b1;
    endcase

    // Illegal encodings still flow down the pipe, but as a harmless no-write op.
    if (ill) begin
      dec.alusel  = ALU_PASSA;
      dec.asel    = 1'b0;
      dec.bsel    = 1'b0;
      dec.imm     = '0;
      dec.rd_we   = 1'b0;
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_ctrl_decode.sv
// Registered RV32I decode stage: one-entry valid/ready pipeline register with
// flush in front of the combinational decoder.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_instr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALUSEL_W-1:0] alusel,
  output logic                asel,
  output logic                bsel,
  output logic [XLEN-1:0]     imm,
  output logic [4:0]          rd,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [2:0]          funct3,
  output logic                rd_we,
  output logic                illegal
);

  decode_t dec_c;
  decode_t dec_d;
  decode_t dec_q;
  logic    valid_d;
  logic    valid_q;
  logic    accept;

  alu_ctrl_comb u_comb (
    .instr (in_instr),
    .dec   (dec_c)
  );

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Flush beats accept; data fields only change on an accepted instruction.
  always_comb begin
    valid_d = valid_q;
    dec_d   = dec_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      dec_d   = dec_c;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      dec_q   <= reset_decode();
    end else begin
      valid_q <= valid_d;
      dec_q   <= dec_d;
    end
  end

  assign out_valid = valid_q;
  assign alusel    = dec_q.alusel;
  assign asel      = dec_q.asel;
  assign bsel      = dec_q.bsel;
  assign imm       = dec_q.imm;
  assign rd        = dec_q.rd;
  assign rs1       = dec_q.rs1;
  assign rs2       = dec_q.rs2;
  assign funct3    = dec_q.funct3;
  assign rd_we     = dec_q.rd_we;
  assign illegal   = dec_q.illegal;

endmodule
